// File: rtl/fx2fp_pkg.sv
// Shared constants and helpers for the Q1.31 -> float32 scheduler.
// Contents:
//   FP_EXP_OFFSET : biased exponent of a magnitude whose top bit is bit 30.
//   FP_ZERO       : float32 +0.0.
//   FP_NEG_ONE    : float32 -1.0.
//   Q31_NEG_ONE   : Q1.31 encoding of -1.0, whose magnitude does not fit in 31 bits.
//   s1_t          : contents of the first pipeline stage, excluding the requester id.
//   q31_mag       : absolute value of a Q1.31 sample, truncated to 31 bits.
package fx2fp_pkg;

    localparam logic [7:0]  FP_EXP_OFFSET = 8'd126;
    localparam logic [31:0] FP_ZERO       = 32'h00000000;
    localparam logic [31:0] FP_NEG_ONE    = 32'hBF800000;
    localparam logic [31:0] Q31_NEG_ONE   = 32'h80000000;

    typedef struct packed {
        logic        sign;
        logic [30:0] mag;
        logic        zero;
        logic        neg_one;
    } s1_t;

    // For -1.0 the 31-bit result is 0. The neg_one flag carries that case instead.
    function automatic logic [30:0] q31_mag(input logic [31:0] x);
        logic [31:0] n;
        n = 32'd0 - x;
        return x[31] ? n[30:0] : x[30:0];
    endfunction

endpackage

// File: rtl/lzd_31bit.sv
// Leading-zero detector for a 31-bit magnitude.
// Ports:
//   in       : magnitude, bit 30 is the most significant.
//   lzd      : number of zeros above the highest set bit (0..30).
//   all_zero : high when in is zero. lzd is then 0 and carries no meaning.
module lzd_31bit (
    input  logic [30:0] in,
    output logic [4:0]  lzd,
    output logic        all_zero
);

    // Scan upward so that the highest set bit writes last.
    always_comb begin
        lzd = 5'd0;
        for (int i = 0; i < 31; i++) begin
            if (in[i]) begin
                lzd = 5'(30 - i);
            end
        end
    end

    assign all_zero = ~|in;

endmodule

// File: rtl/fx2fp_rr_scheduler.sv
// Round-robin scheduler that shares one Q1.31 -> float32 normaliser among NUM_REQ sources.
// Ports:
//   clk, reset  : single rising-edge clock and synchronous active-high reset.
//   req_valid   : per-lane sample valid.
//   req_data    : per-lane Q1.31 sample. Lane i occupies [32*i+31:32*i].
//   req_ready   : one-hot grant, combinational.
//   out_valid   : result stream valid.
//   out_ready   : downstream accepts the result.
//   out_data    : float32 result.
//   out_id      : requester index of the result.
//   dbg_rr_ptr  : current round-robin pointer, for observation only.
//
// Handshake rules apply to both the request ports and the result port.
// A transfer happens on a rising edge where valid && ready.
// The source holds valid and its payload stable until that edge.
// Ready never depends on the same port's ready.
//
// Pipeline:
//   S1 holds the sign, the magnitude and the special-case flags.
//   S2 holds the packed float and is the output register.
// Results leave in acceptance order, 2 cycles after acceptance.
module fx2fp_rr_scheduler
    import fx2fp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [32*NUM_REQ-1:0]  req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_data,
    output logic [ID_W-1:0]        out_id,
    output logic [ID_W-1:0]        dbg_rr_ptr
);

    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic               s1_valid_q;
    s1_t                s1_q, s1_d;
    logic [ID_W-1:0]    s1_id_q;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic [ID_W-1:0]    out_id_q;

    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               found;
    logic               s2_load;
    logic               s1_free;
    logic               accept;
    logic [31:0]        sel_data;
    logic [4:0]         lz;
    logic               mag_zero;
    logic [7:0]         fp_exp;
    logic [22:0]        fp_frac;
    logic [31:0]        fp_res;

    // The search starts at the pointer and wraps, so the first valid lane at or
    // after the pointer gets the grant.
    always_comb begin : arb
        int idx;
        idx      = 0;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    // S2 loads when it is empty or is being read out this cycle.
    assign s2_load = s1_valid_q && (!out_valid_q || out_ready);
    // S1 can take a new sample when it is empty or is moving into S2.
    assign s1_free = !s1_valid_q || s2_load;

    // No grant is issued during reset.
    assign req_ready = (s1_free && !reset) ? grant : '0;
    assign accept    = found && s1_free && !reset;

    assign sel_data = req_data[32*int'(grant_id) +: 32];

    always_comb begin
        s1_d.sign    = sel_data[31];
        s1_d.mag     = q31_mag(sel_data);
        s1_d.zero    = (sel_data == FP_ZERO);
        s1_d.neg_one = (sel_data == Q31_NEG_ONE);
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
        end
    end

    lzd_31bit u_lzd (
        .in       (s1_q.mag),
        .lzd      (lz),
        .all_zero (mag_zero)
    );

    // After the shift, bit 30 holds the hidden one.
    // Bits 29:7 become the fraction, truncated toward zero.
    assign fp_exp  = FP_EXP_OFFSET - {3'b000, lz};
    assign fp_frac = 23'((s1_q.mag << lz) >> 7);

    always_comb begin
        if (s1_q.neg_one) begin
            fp_res = FP_NEG_ONE;
        end else if (s1_q.zero || mag_zero) begin
            fp_res = FP_ZERO;
        end else begin
            fp_res = {s1_q.sign, fp_exp, fp_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            s1_id_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (s1_free) begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_q    <= s1_d;
                    s1_id_q <= grant_id;
                end
            end
            // S2 holds its contents while the result is stalled downstream.
            if (!out_valid_q || out_ready) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_data_q <= fp_res;
                    out_id_q   <= s1_id_q;
                end
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_id     = out_id_q;
    assign dbg_rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_fx2fp_rr_scheduler.sv
// Directed bench for fx2fp_rr_scheduler with NUM_REQ=4.
// Inputs change on the falling edge.
// Outputs and the combinational grant are checked 1 time unit later, before the next rising edge.
module tb_fx2fp_rr_scheduler;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_valid;
    logic [127:0] req_data;
    logic [3:0]   req_ready;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_id;
    logic [1:0]   dbg_rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    logic [33:0]  exp_q[$];
    logic [31:0]  lane_in  [4];
    logic [31:0]  lane_out [4];

    always #5 clk = ~clk;

    fx2fp_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_id     (out_id),
        .dbg_rr_ptr (dbg_rr_ptr)
    );

    task automatic set_lane(input int lane, input logic [31:0] v);
        req_data[32*lane +: 32] = v;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 4'hF; out_ready = 1'b1; req_data = '0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_checks++; if (out_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", out_id); end
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL reset_ptr: got %0d want 0", dbg_rr_ptr); end
        @(negedge clk);
        reset = 1'b0; req_valid = 4'h0;
    endtask

    // Sends one sample on a single lane and follows it to the output.
    task automatic send_one(input int lane, input logic [31:0] x, input logic [31:0] want, input string name);
        logic [3:0] g;
        g = 4'b0001 << lane;
        @(negedge clk);
        set_lane(lane, x); req_valid = g; out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== g) begin n_fail++; $display("FAIL %s_grant: got %b want %b", name, req_ready, g); end
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_early: out_valid=%b want 0", name, out_valid); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_valid: got %b want 1", name, out_valid); end
        n_checks++; if (out_data !== want) begin n_fail++; $display("FAIL %s_data: got %h want %h", name, out_data, want); end
        n_checks++; if (out_id !== 2'(lane)) begin n_fail++; $display("FAIL %s_id: got %0d want %0d", name, out_id, lane); end
        n_checks++; if (dbg_rr_ptr !== 2'((lane + 1) % 4)) begin n_fail++; $display("FAIL %s_ptr: got %0d want %0d", name, dbg_rr_ptr, (lane + 1) % 4); end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_single: out_valid=%b want 0", name, out_valid); end
    endtask

    task automatic test_single;
        send_one(0, 32'h40000000, 32'h3F000000, "single_half");
    endtask

    task automatic test_boundary;
        send_one(1, 32'h00000000, 32'h00000000, "bnd_zero");
        send_one(2, 32'h80000000, 32'hBF800000, "bnd_neg_one");
        send_one(0, 32'h00000001, 32'h30000000, "bnd_lsb");
        send_one(2, 32'hC0000000, 32'hBF000000, "bnd_neg_half");
        send_one(1, 32'h7FFFFFFF, 32'h3F7FFFFF, "bnd_max");
        send_one(0, 32'hFFFFFFFF, 32'hB0000000, "bnd_neg_lsb");
        send_one(1, 32'h12345678, 32'h3E11A2B3, "bnd_mixed");
        send_one(3, 32'h00000100, 32'h34000000, "bnd_pow2");
    endtask

    // All lanes are valid for 8 cycles, starting from pointer 0.
    task automatic test_back_to_back;
        logic [3:0]  g;
        logic [33:0] e;
        lane_in[0] = 32'h40000000; lane_out[0] = 32'h3F000000;
        lane_in[1] = 32'hC0000000; lane_out[1] = 32'hBF000000;
        lane_in[2] = 32'h00000001; lane_out[2] = 32'h30000000;
        lane_in[3] = 32'h60000000; lane_out[3] = 32'h3F400000;
        for (int i = 0; i < 4; i++) set_lane(i, lane_in[i]);
        exp_q.delete();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_valid = (c < 8) ? 4'hF : 4'h0; out_ready = 1'b1;
            #1;
            if (c < 8) begin
                g = 4'b0001 << (c % 4);
                n_checks++; if (req_ready !== g) begin n_fail++; $display("FAIL rr_grant c%0d: got %b want %b", c, req_ready, g); end
                exp_q.push_back({2'(c % 4), lane_out[c % 4]});
            end
            if (c >= 2) begin
                n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid c%0d: got %b want 1", c, out_valid); end
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    n_checks++; if ({out_id, out_data} !== e) begin n_fail++; $display("FAIL rr_result c%0d: got id %0d data %h want id %0d data %h", c, out_id, out_data, e[33:32], e[31:0]); end
                end
            end
        end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain: out_valid=%b want 0", out_valid); end
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rr_count: %0d results missing, want 0", exp_q.size()); end
        n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rr_ptr: got %0d want 0", dbg_rr_ptr); end
    endtask

    // out_ready is held low for 5 cycles while every lane requests.
    task automatic test_stall;
        @(negedge clk);
        req_valid = 4'hF; out_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_g0: got %b want 0001", req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_g1: got %b want 0010", req_ready); end
        for (int c = 2; c < 5; c++) begin
            @(negedge clk);
            #1;
            n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_ready c%0d: got %b want 0000", c, req_ready); end
            n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 32'h3F000000}) begin
                n_fail++; $display("FAIL stall_hold c%0d: got v%b id %0d %h want v1 id 0 3f000000", c, out_valid, out_id, out_data);
            end
        end
        @(negedge clk);
        out_ready = 1'b1; req_valid = 4'h0;
        #1;
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 32'h3F000000}) begin
            n_fail++; $display("FAIL stall_out0: got v%b id %0d %h want v1 id 0 3f000000", out_valid, out_id, out_data);
        end
        @(negedge clk);
        #1;
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd1, 32'hBF000000}) begin
            n_fail++; $display("FAIL stall_out1: got v%b id %0d %h want v1 id 1 bf000000", out_valid, out_id, out_data);
        end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_dup: out_valid=%b want 0", out_valid); end
        n_checks++; if (dbg_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL stall_ptr: got %0d want 2", dbg_rr_ptr); end
    endtask

    // Only lanes 1 and 3 request while the pointer is at 2.
    task automatic test_skip;
        @(negedge clk);
        req_valid = 4'b1010; out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL skip_g3: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0010;
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL skip_g1: got %b want 0010", req_ready); end
        n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL skip_ptr0: got %0d want 0", dbg_rr_ptr); end
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        n_checks++; if (dbg_rr_ptr !== 2'd2) begin n_fail++; $display("FAIL skip_ptr2: got %0d want 2", dbg_rr_ptr); end
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd3, 32'h3F400000}) begin
            n_fail++; $display("FAIL skip_out3: got v%b id %0d %h want v1 id 3 3f400000", out_valid, out_id, out_data);
        end
        @(negedge clk);
        #1;
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd1, 32'hBF000000}) begin
            n_fail++; $display("FAIL skip_out1: got v%b id %0d %h want v1 id 1 bf000000", out_valid, out_id, out_data);
        end
    endtask

    // Both stages are filled, then reset is pulsed for one cycle.
    task automatic test_reset_mid;
        @(negedge clk);
        req_valid = 4'hF; out_ready = 1'b0;
        #1;
        n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rst_g2: got %b want 0100", req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if (req_ready !== 4'b1000) begin n_fail++; $display("FAIL rst_g3: got %b want 1000", req_ready); end
        @(negedge clk);
        #1;
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd2, 32'h30000000}) begin
            n_fail++; $display("FAIL rst_full: got v%b id %0d %h want v1 id 2 30000000", out_valid, out_id, out_data);
        end
        reset = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", req_ready); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b0, 2'd0, 32'h0}) begin
            n_fail++; $display("FAIL rst_out: got v%b id %0d %h want v0 id 0 00000000", out_valid, out_id, out_data);
        end
        n_checks++; if (dbg_rr_ptr !== 2'd0) begin n_fail++; $display("FAIL rst_ptr: got %0d want 0", dbg_rr_ptr); end
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_g0: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_flushed: out_valid=%b want 0", out_valid); end
        @(negedge clk);
        #1;
        n_checks++; if ({out_valid, out_id, out_data} !== {1'b1, 2'd0, 32'h3F000000}) begin
            n_fail++; $display("FAIL rst_after: got v%b id %0d %h want v1 id 0 3f000000", out_valid, out_id, out_data);
        end
        @(negedge clk);
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_extra: out_valid=%b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_boundary();
        test_back_to_back();
        test_stall();
        test_skip();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
